// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and defaults for the instruction fetch unit and the
// instruction memory it reads from.
//   ifetch_state_t : fetch FSM states
//   ADDR_W_DEF     : default IRAM address width
//   INSTR_W_DEF    : default instruction width
//   END_OP_DEF     : default opcode that halts fetching
// ----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 8;
   localparam logic [7:0] END_OP_DEF = 8'hFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      VALID = 3'd3,
      DONE  = 3'd4
   } ifetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// ----------------------------------------------------------------------------
// pc_counter
// Program counter register with prioritised load / jump / increment / hold.
// pc_next is exposed so the fetch FSM can issue the new address on the same
// edge the PC is updated.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pc <= START_ADDR)
//   load_start  : load START_ADDR
//   load_jump   : load jump_addr
//   inc         : pc + 1, wrapping modulo 2**ADDR_W
//   jump_addr   : jump target
//   pc          : registered program counter
//   pc_next     : value pc takes at the next edge (absent reset)
// ----------------------------------------------------------------------------
module pc_counter
   import ifetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_jump,
   input  logic              inc,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   // Next-PC selection; the plain add wraps naturally at the top of the space.
   always_comb begin
      pc_next = pc;
      if (load_start) begin
         pc_next = START_ADDR;
      end else if (load_jump) begin
         pc_next = jump_addr;
      end else if (inc) begin
         pc_next = pc + PC_ONE;
      end else begin
         pc_next = pc;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= START_ADDR;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Initiator side of the instruction-memory read port. Issues one IRAM read,
// captures the registered IRAM data a cycle later and offers it to the
// control unit on a valid/ready handshake. Halts on END_OP; restarts on start.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin fetching from START_ADDR (IDLE/DONE only)
//   read_IRAM    : IRAM read enable (registered, single-cycle pulses)
//   addr         : IRAM address (registered, held between issues)
//   instr_in     : IRAM data, valid the cycle after read_IRAM was sampled
//   instr_valid  : instr holds a fetched instruction
//   instr_ready  : control unit accepts instr when instr_valid=1
//   instr        : held instruction
//   jump_en      : with an accepted instr, next fetch from jump_addr
//   jump_addr    : jump target
//   pc           : address of instruction held / being fetched
//   busy         : fetching (ISSUE/WAIT/VALID)
//   done         : END_OP accepted
// ----------------------------------------------------------------------------
module instr_fetch_unit
   import ifetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0]  START_ADDR = {ADDR_W{1'b0}},
   parameter logic [INSTR_W-1:0] END_OP     = END_OP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               read_IRAM,
   output logic [ADDR_W-1:0]  addr,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   input  logic               jump_en,
   input  logic [ADDR_W-1:0]  jump_addr,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done
);

   ifetch_state_t     state_r;
   logic              load_start_s;
   logic              accept_s;
   logic              is_end_s;
   logic              load_jump_s;
   logic              inc_s;
   logic [ADDR_W-1:0] pc_next_s;

   // Decode handshake events into PC control strobes.
   always_comb begin
      load_start_s = 1'b0;
      accept_s     = 1'b0;
      is_end_s     = 1'b0;
      load_jump_s  = 1'b0;
      inc_s        = 1'b0;
      if ((state_r == IDLE) || (state_r == DONE)) begin
         load_start_s = start;
      end else begin
         load_start_s = 1'b0;
      end
      accept_s    = (state_r == VALID) && instr_ready;
      is_end_s    = (instr == END_OP);
      // An accepted END_OP freezes the PC and ignores any jump request.
      load_jump_s = accept_s && !is_end_s && jump_en;
      inc_s       = accept_s && !is_end_s && !jump_en;
   end

   pc_counter #(
      .ADDR_W     (ADDR_W),
      .START_ADDR (START_ADDR)
   ) u_pc_counter (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start_s),
      .load_jump  (load_jump_s),
      .inc        (inc_s),
      .jump_addr  (jump_addr),
      .pc         (pc),
      .pc_next    (pc_next_s)
   );

   // Fetch FSM with registered IRAM and control-unit outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         read_IRAM   <= 1'b0;
         addr        <= {ADDR_W{1'b0}};
         instr       <= {INSTR_W{1'b0}};
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               read_IRAM <= 1'b0;
               if (start) begin
                  state_r   <= ISSUE;
                  read_IRAM <= 1'b1;
                  addr      <= pc_next_s;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            ISSUE: begin
               state_r   <= WAIT;
               read_IRAM <= 1'b0;
            end
            WAIT: begin
               // IRAM output registered its data at the ISSUE->WAIT edge.
               state_r     <= VALID;
               instr       <= instr_in;
               instr_valid <= 1'b1;
            end
            VALID: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (is_end_s) begin
                     state_r <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_r   <= ISSUE;
                     read_IRAM <= 1'b1;
                     addr      <= pc_next_s;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               read_IRAM   <= 1'b0;
               instr_valid <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a behavioural registered IRAM.
// Outputs are sampled 1 time unit after the rising edge; inputs change there.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       read_IRAM;
   logic [7:0] addr;
   logic [7:0] iram_out;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic [7:0] pc;
   logic       busy;
   logic       done;

   logic [7:0] iram [0:255];
   int vectors   = 0;
   int miscompares = 0;

   // {read_IRAM, addr, instr_valid, instr, pc, busy, done}
   logic [27:0] obs;
   assign obs = {read_IRAM, addr, instr_valid, instr, pc, busy, done};

   always #5 clk = ~clk;

   // Registered IRAM read port.
   always @(posedge clk) begin
      if (read_IRAM) iram_out <= iram[addr];
   end

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .read_IRAM   (read_IRAM),
      .addr        (addr),
      .instr_in    (iram_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 8 && !instr_valid; i++) step();
      vectors++;
      if (instr_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_timeout: instr_valid=%b required 1", name, instr_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if (obs !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got %h required %h", obs, {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      start = 1'b1;
      instr_ready = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if (obs !== {1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_issue0: got %h required %h", obs, {1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
      end
      step();
      vectors++;
      if (obs !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_wait0: got %h required %h", obs, {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
      end
      step();
      vectors++;
      if (obs !== {1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_valid0: got %h required %h", obs, {1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b1, 1'b0});
      end
      step();
      vectors++;
      if (obs !== {1'b1, 8'h01, 1'b0, 8'h11, 8'h01, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_issue1: got %h required %h", obs, {1'b1, 8'h01, 1'b0, 8'h11, 8'h01, 1'b1, 1'b0});
      end
      step();
      step();
      vectors++;
      if (obs !== {1'b0, 8'h01, 1'b1, 8'h22, 8'h01, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_valid1: got %h required %h", obs, {1'b0, 8'h01, 1'b1, 8'h22, 8'h01, 1'b1, 1'b0});
      end
      step();
      step();
      step();
      instr_ready = 1'b0;
      vectors++;
      if (obs !== {1'b0, 8'h02, 1'b1, 8'h33, 8'h02, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_valid2: got %h required %h", obs, {1'b0, 8'h02, 1'b1, 8'h33, 8'h02, 1'b1, 1'b0});
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (obs !== {1'b0, 8'h02, 1'b1, 8'h33, 8'h02, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got %h required %h", i, obs, {1'b0, 8'h02, 1'b1, 8'h33, 8'h02, 1'b1, 1'b0});
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      vectors++;
      if (obs !== {1'b1, 8'h03, 1'b0, 8'h33, 8'h03, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL stall_release: got %h required %h", obs, {1'b1, 8'h03, 1'b0, 8'h33, 8'h03, 1'b1, 1'b0});
      end
      wait_valid("stall");
      vectors++;
      if ({instr, pc} !== {8'h44, 8'h03}) begin
         miscompares++;
         $display("FAIL stall_next: got %h required %h", {instr, pc}, {8'h44, 8'h03});
      end
   endtask

   task automatic test_jump();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      wait_valid("jump_pre");
      vectors++;
      if ({instr, pc} !== {8'h55, 8'h04}) begin
         miscompares++;
         $display("FAIL jump_pc4: got %h required %h", {instr, pc}, {8'h55, 8'h04});
      end
      instr_ready = 1'b1;
      jump_en = 1'b1;
      jump_addr = 8'h40;
      step();
      instr_ready = 1'b0;
      jump_en = 1'b0;
      vectors++;
      if ({read_IRAM, addr, pc} !== {1'b1, 8'h40, 8'h40}) begin
         miscompares++;
         $display("FAIL jump_issue: got %h required %h", {read_IRAM, addr, pc}, {1'b1, 8'h40, 8'h40});
      end
      wait_valid("jump");
      vectors++;
      if ({instr, pc} !== {8'hA4, 8'h40}) begin
         miscompares++;
         $display("FAIL jump_instr: got %h required %h", {instr, pc}, {8'hA4, 8'h40});
      end
   endtask

   task automatic test_end();
      instr_ready = 1'b1;
      jump_en = 1'b1;
      jump_addr = 8'h05;
      step();
      instr_ready = 1'b0;
      jump_en = 1'b0;
      wait_valid("end_pre");
      vectors++;
      if ({instr, pc} !== {8'hFF, 8'h05}) begin
         miscompares++;
         $display("FAIL end_fetch: got %h required %h", {instr, pc}, {8'hFF, 8'h05});
      end
      // jump request alongside END must be ignored
      instr_ready = 1'b1;
      jump_en = 1'b1;
      jump_addr = 8'h77;
      step();
      instr_ready = 1'b0;
      jump_en = 1'b0;
      vectors++;
      if (obs !== {1'b0, 8'h05, 1'b0, 8'hFF, 8'h05, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL end_done: got %h required %h", obs, {1'b0, 8'h05, 1'b0, 8'hFF, 8'h05, 1'b0, 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if ({read_IRAM, done, busy} !== {1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL end_idle%0d: got %b required %b", i, {read_IRAM, done, busy}, {1'b0, 1'b1, 1'b0});
         end
      end
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if (obs !== {1'b1, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL end_restart: got %h required %h", obs, {1'b1, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0});
      end
      wait_valid("restart");
      vectors++;
      if ({instr, pc} !== {8'h11, 8'h00}) begin
         miscompares++;
         $display("FAIL end_refetch: got %h required %h", {instr, pc}, {8'h11, 8'h00});
      end
   endtask

   task automatic test_wrap();
      instr_ready = 1'b1;
      jump_en = 1'b1;
      jump_addr = 8'hFF;
      step();
      instr_ready = 1'b0;
      jump_en = 1'b0;
      wait_valid("wrap_pre");
      vectors++;
      if ({instr, pc} !== {8'h0F, 8'hFF}) begin
         miscompares++;
         $display("FAIL wrap_top: got %h required %h", {instr, pc}, {8'h0F, 8'hFF});
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      vectors++;
      if ({read_IRAM, addr, pc} !== {1'b1, 8'h00, 8'h00}) begin
         miscompares++;
         $display("FAIL wrap_issue: got %h required %h", {read_IRAM, addr, pc}, {1'b1, 8'h00, 8'h00});
      end
      wait_valid("wrap");
      vectors++;
      if ({instr, pc} !== {8'h11, 8'h00}) begin
         miscompares++;
         $display("FAIL wrap_instr: got %h required %h", {instr, pc}, {8'h11, 8'h00});
      end
   endtask

   task automatic test_reset_mid();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      step();
      vectors++;
      if (obs !== {1'b0, 8'h01, 1'b0, 8'h11, 8'h01, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL rstmid_wait: got %h required %h", obs, {1'b0, 8'h01, 1'b0, 8'h11, 8'h01, 1'b1, 1'b0});
      end
      rst = 1'b1;
      start = 1'b1;
      step();
      rst = 1'b0;
      start = 1'b0;
      vectors++;
      if (obs !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rstmid_reset: got %h required %h", obs, {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
      end
      step();
      vectors++;
      if (obs !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rstmid_idle: got %h required %h", obs, {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) iram[i] = i[7:0] + 8'h10;
      iram[8'h00] = 8'h11;
      iram[8'h01] = 8'h22;
      iram[8'h02] = 8'h33;
      iram[8'h03] = 8'h44;
      iram[8'h04] = 8'h55;
      iram[8'h05] = 8'hFF;
      iram[8'h40] = 8'hA4;
      iram[8'hFF] = 8'h0F;
      rst = 1'b1;
      start = 1'b0;
      instr_ready = 1'b0;
      jump_en = 1'b0;
      jump_addr = 8'h00;
      test_reset();
      test_basic();
      test_stall();
      test_jump();
      test_end();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
